// File: rtl/reg_arbiter.sv
// Two-source register-file arbiter: a non-stallable SPI port with a one-entry
// buffer and a level-handshake internal requester, alternating on ties.
module reg_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] spi_regnum,
    input  logic       spi_read,
    input  logic       spi_write,
    input  logic [7:0] spi_wdata,
    output logic [7:0] spi_rdata,
    output logic       spi_rvalid,
    output logic       spi_ovf,
    input  logic       int_req,
    input  logic       int_we,
    input  logic [6:0] int_regnum,
    input  logic [7:0] int_wdata,
    output logic       int_gnt,
    output logic       int_done,
    output logic [7:0] int_rdata,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_rd,
    output logic       reg_wr,
    input  logic [7:0] reg_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t     state;

    logic       buf_valid;
    logic       buf_we;
    logic [6:0] buf_regnum;
    logic [7:0] buf_wdata;

    logic       last_int;
    logic       cur_spi;
    logic       cur_we;

    logic       spi_strobe;
    logic       sel_spi;
    logic       sel_int;
    logic       buf_accept;

    // On a tie the source that was not served last wins.
    assign spi_strobe = spi_read | spi_write;
    assign sel_spi    = (state == IDLE) && buf_valid && (!int_req || last_int);
    assign sel_int    = (state == IDLE) && int_req && !sel_spi;
    // A strobe may refill the buffer in the same cycle it is being drained.
    assign buf_accept = spi_strobe && (!buf_valid || sel_spi);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid  <= 1'b0;
            buf_we     <= 1'b0;
            buf_regnum <= 7'd0;
            buf_wdata  <= 8'd0;
            spi_ovf    <= 1'b0;
        end else begin
            if (buf_accept) begin
                buf_valid  <= 1'b1;
                buf_we     <= spi_write;
                buf_regnum <= spi_regnum;
                buf_wdata  <= spi_wdata;
            end else if (sel_spi) begin
                buf_valid  <= 1'b0;
            end
            if (spi_strobe && !buf_accept) begin
                spi_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_int   <= 1'b1;
            cur_spi    <= 1'b0;
            cur_we     <= 1'b0;
            spi_rdata  <= 8'd0;
            spi_rvalid <= 1'b0;
            int_gnt    <= 1'b0;
            int_done   <= 1'b0;
            int_rdata  <= 8'd0;
            reg_addr   <= 7'd0;
            reg_wdata  <= 8'd0;
            reg_rd     <= 1'b0;
            reg_wr     <= 1'b0;
        end else begin
            spi_rvalid <= 1'b0;
            int_gnt    <= 1'b0;
            int_done   <= 1'b0;
            reg_rd     <= 1'b0;
            reg_wr     <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_spi) begin
                        cur_spi   <= 1'b1;
                        cur_we    <= buf_we;
                        reg_addr  <= buf_regnum;
                        reg_wdata <= buf_wdata;
                        reg_rd    <= !buf_we;
                        reg_wr    <= buf_we;
                        last_int  <= 1'b0;
                        state     <= ISSUE;
                    end else if (sel_int) begin
                        cur_spi   <= 1'b0;
                        cur_we    <= int_we;
                        reg_addr  <= int_regnum;
                        reg_wdata <= int_wdata;
                        reg_rd    <= !int_we;
                        reg_wr    <= int_we;
                        int_gnt   <= 1'b1;
                        last_int  <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // SPI writes complete silently; internal writes still report done.
                    if (cur_we) begin
                        int_done <= !cur_spi;
                        state    <= RESP;
                    end else begin
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (cur_spi) begin
                        spi_rdata  <= reg_rdata;
                        spi_rvalid <= 1'b1;
                    end else begin
                        int_rdata  <= reg_rdata;
                        int_done   <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
